// File: rtl/aes128_decrypt_core_if.sv
// Handshake bundle for the AES-128 decrypt core: ciphertext/key request and plaintext response.
interface aes128_decrypt_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [128:1] key;
    logic [128:1] cipher;
    logic         out_valid;
    logic         out_ready;
    logic [128:1] plain;
    logic         busy;

    modport master (
        output in_valid, key, cipher, out_ready,
        input  in_ready, out_valid, plain, busy
    );

    modport slave (
        input  in_valid, key, cipher, out_ready,
        output in_ready, out_valid, plain, busy
    );
endinterface

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per cycle, with on-the-fly key expansion
// and a last-key cache that skips expansion when the same key is presented again.
module aes128_decrypt_core (
    input  logic                 clk,
    input  logic                 rst_n,
    aes128_decrypt_core_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} fsm_t;

    // GF(2^8) arithmetic; the S-box is derived from the field inverse and the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] s_box(input logic [7:0] a, input logic mode);
        logic [7:0] t;
        if (mode) begin
            t = gf_inv(a);
            return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
        end
        t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [128:1] sub_bytes(input logic [128:1] s, input logic mode);
        logic [128:1] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[128-8*i -: 8] = s_box(s[128-8*i -: 8], mode);
        return o;
    endfunction

    // Byte (row r, column c) lives at index r + 4c.
    function automatic logic [128:1] shift_rows(input logic [128:1] s, input logic mode);
        logic [128:1] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = mode ? (c + r) % 4 : (c - r + 4) % 4;
                o[128-8*(r+4*c) -: 8] = s[128-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [128:1] mix_columns(input logic [128:1] s, input logic mode);
        logic [128:1] o;
        logic [31:0]  coeff;
        logic [7:0]   acc;
        o     = '0;
        coeff = mode ? 32'h02030101 : 32'h0e0b0d09;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coeff[31-8*((j-r+4)%4) -: 8], s[128-8*(j+4*c) -: 8]);
                o[128-8*(r+4*c) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [128:1] next_rk(input logic [128:1] prev, input logic [7:0] rc);
        logic [31:0]  w3;
        logic [31:0]  temp;
        logic [128:1] n;
        w3   = prev[32:1];
        temp = {s_box(w3[23:16], 1'b1), s_box(w3[15:8], 1'b1),
                s_box(w3[7:0], 1'b1), s_box(w3[31:24], 1'b1)} ^ {rc, 24'h0};
        n[128:97] = prev[128:97] ^ temp;
        n[96:65]  = prev[96:65]  ^ n[128:97];
        n[64:33]  = prev[64:33]  ^ n[96:65];
        n[32:1]   = prev[32:1]   ^ n[64:33];
        return n;
    endfunction

    fsm_t         fsm, fsm_nx;
    logic [128:1] rk [0:10];
    logic [128:1] state;
    logic [128:1] plain_q;
    logic [128:1] kcache;
    logic [3:0]   rnd;
    logic         key_loaded;

    logic [3:0]   prev_idx;
    logic [128:1] exp_rk;
    logic [128:1] inv_core;
    logic [128:1] round_out;
    logic         key_hit;

    assign prev_idx  = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
    assign exp_rk    = next_rk(rk[prev_idx], rcon(rnd));
    assign inv_core  = sub_bytes(shift_rows(state, 1'b0), 1'b0);
    assign round_out = mix_columns(inv_core ^ rk[rnd], 1'b0);
    assign key_hit   = key_loaded && (bus.key == kcache);

    assign bus.in_ready  = (fsm == IDLE);
    assign bus.out_valid = (fsm == DONE);
    assign bus.busy      = (fsm != IDLE);
    assign bus.plain     = plain_q;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fsm_nx = fsm;
        case (fsm)
            IDLE:    if (bus.in_valid) fsm_nx = key_hit ? ROUND : EXPAND;
            EXPAND:  if (rnd == 4'd10) fsm_nx = ROUND;
            ROUND:   if (rnd == 4'd0) fsm_nx = DONE;
            DONE:    if (bus.out_ready) fsm_nx = IDLE;
            default: fsm_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nx;
    end

    // NOTE: the round-key file is reset explicitly; a reset must leave no stale key that could look like a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) rk[i] <= '0;
            state      <= '0;
            plain_q    <= '0;
            kcache     <= '0;
            rnd        <= '0;
            key_loaded <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (bus.in_valid) begin
                    rk[0]  <= bus.key;
                    kcache <= bus.key;
                    if (key_hit) begin
                        state <= bus.cipher ^ rk[10];
                        rnd   <= 4'd9;
                    end else begin
                        state      <= bus.cipher;
                        key_loaded <= 1'b0;
                        rnd        <= 4'd1;
                    end
                end
                EXPAND: begin
                    rk[rnd] <= exp_rk;
                    if (rnd == 4'd10) begin
                        state      <= state ^ exp_rk;
                        key_loaded <= 1'b1;
                        rnd        <= 4'd9;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ROUND: begin
                    if (rnd != 4'd0) begin
                        state <= round_out;
                        rnd   <= rnd - 4'd1;
                    end else begin
                        state   <= inv_core ^ rk[0];
                        plain_q <= inv_core ^ rk[0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Self-checking bench: a byte-level AES-128 encryptor produces ciphertexts, and the core must
// return the original plaintext with the latency implied by the bench's own key-cache model.
module tb_aes128_decrypt_core;

    logic clk;
    logic rst_n;

    aes128_decrypt_core_if bus ();

    aes128_decrypt_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_tab [256];
    logic         model_loaded = 1'b0;
    logic [127:0] model_key    = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less product followed by polynomial long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        int p;
        int aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (aa << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
        return p[7:0];
    endfunction

    // Forward S-box from its definition: brute-force field inverse, then the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul_ref(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gf_mul_ref(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) t[r] = s[r+4*c];
                    s[4*c+0] = gf_mul_ref(t[0], 8'h02) ^ gf_mul_ref(t[1], 8'h03) ^ t[2] ^ t[3];
                    s[4*c+1] = t[0] ^ gf_mul_ref(t[1], 8'h02) ^ gf_mul_ref(t[2], 8'h03) ^ t[3];
                    s[4*c+2] = t[0] ^ t[1] ^ gf_mul_ref(t[2], 8'h02) ^ gf_mul_ref(t[3], 8'h03);
                    s[4*c+3] = gf_mul_ref(t[0], 8'h03) ^ t[1] ^ t[2] ^ gf_mul_ref(t[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic send(input logic [127:0] k, input logic [127:0] c);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) check("in_ready_wait", {127'b0, bus.in_ready}, 128'd1);
        bus.key      = k;
        bus.cipher   = c;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.key      = rand128();
        bus.cipher   = rand128();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic do_block(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                            input int gap, input int hold, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (model_loaded && k == model_key) ? 10 : 20;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
        send(k, c);
        wait_out(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_plain"}, bus.plain, p);
        model_loaded = 1'b1;
        model_key    = k;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {bus.out_valid, bus.in_ready, bus.plain}, {1'b1, 1'b0, p});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_post"}, {126'b0, bus.out_valid, bus.in_ready}, 128'b01);
    endtask

    logic [127:0] k_c1, k_b, c_b, p_b, k_r, p_r, prev_k;

    initial begin
        build_sbox();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.key       = '0;
        bus.cipher    = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.in_ready, bus.out_valid, bus.busy, bus.plain},
              {1'b1, 1'b0, 1'b0, 128'h0});
        rst_n = 1'b1;

        // All-zero key right after reset must not hit the zeroed cache.
        p_r = rand128();
        do_block(128'h0, aes_encrypt(128'h0, p_r), p_r, 1, 0, "zero_key");

        k_c1 = 128'h000102030405060708090a0b0c0d0e0f;
        do_block(k_c1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                 128'h00112233445566778899aabbccddeeff, 0, 0, "fips_c1");
        do_block(k_c1, aes_encrypt(k_c1, 128'hffeeddccbbaa99887766554433221100),
                 128'hffeeddccbbaa99887766554433221100, 0, 0, "c1_hit");

        k_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        c_b = 128'h3925841d02dc09fbdc118597196a0b32;
        p_b = 128'h3243f6a8885a308d313198a2e0370734;
        do_block(k_b, c_b, p_b, 2, 7, "fips_b_bp");

        // Abort a cache-hit block at rnd=5 (four edges after acceptance).
        send(k_b, c_b);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset", {bus.in_ready, bus.out_valid, bus.busy, bus.plain},
              {1'b1, 1'b0, 1'b0, 128'h0});
        @(posedge clk); #1;
        rst_n        = 1'b1;
        model_loaded = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen++;
            end
            check("no_out_after_reset", seen, 0);
        end
        do_block(k_b, c_b, p_b, 0, 0, "post_reset");

        prev_k = k_b;
        for (int n = 0; n < 200; n++) begin
            k_r = ($urandom_range(0, 1) == 1) ? prev_k : rand128();
            p_r = rand128();
            do_block(k_r, aes_encrypt(k_r, p_r), p_r,
                     $urandom_range(0, 3), $urandom_range(0, 3), "random");
            prev_k = k_r;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_core.md
# aes128_decrypt_core

Iterative AES-128 decryption engine: it accepts a 128-bit ciphertext block and a 128-bit key over a valid/ready handshake, and returns the plaintext over a second handshake. Rounds run one per cycle in the FIPS-197 inverse-cipher order. The block is the decrypt counterpart of the `encrypt_func` path, and `aes128_decrypt_core(encrypt_func(key, p), key) = p` for every `key` and `p`. A last-key cache skips key expansion when consecutive blocks use the same key.

## Interface
Parameters: none (AES-128 only: Nk=4, Nr=10).

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `key`/`cipher` valid
- `in_ready`  out  1  core can accept a block
- `key`  in  [128:1]  cipher key
- `cipher`  in  [128:1]  ciphertext block
- `out_valid`  out  1  `plain` valid
- `out_ready`  in  1  consumer accepts `plain`
- `plain`  out  [128:1]  plaintext block
- `busy`  out  1  high in any state other than IDLE

Byte packing matches `encrypt_func` and `expand_key`: byte 0 is in bits [128:121], and column-major state order follows FIPS-197. Round key r occupies bits [128*r+1 +: 128] of the 1408-bit schedule.

## Operation
- Per-round transforms: `s_box`, `shift_rows` and `mix_columns` are used with mode bit 0 (inverse). Key expansion is computed one round key per cycle using SubWord, RotWord and Rcon.
- Internal storage:
  - `rk[0..10]`: 11×128 round-key registers
  - `state`: 128-bit state register
  - `rnd`: 4-bit round counter
  - `kcache`: 128-bit copy of the last expanded key
  - `key_loaded`: 1-bit flag
- FSM states: IDLE, EXPAND, ROUND, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`, latch `cipher` into `state` and `key` into `rk[0]`/`kcache`.
  - If `key_loaded` and `key==kcache`: set `state` to `cipher ^ rk[10]`, set `rnd` to 9, go to ROUND.
  - Otherwise: clear `key_loaded`, set `rnd` to 1, go to EXPAND.
- **EXPAND**
  - Each cycle, `rk[rnd]` is loaded with `next_rk(rk[rnd-1], Rcon[rnd])` and `rnd` increments.
  - On the cycle that writes `rk[10]`, `state` is also loaded with `state ^ next_rk` (the round-key-10 addition), `key_loaded` is set, `rnd` is set to 9, and the FSM goes to ROUND.
- **ROUND**
  - When `rnd ≥ 1`: `state` is loaded with `InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd])`.
  - When `rnd == 0`: `state` is loaded with `InvSubBytes(InvShiftRows(state)) ^ rk[0]`, `plain` is loaded with the same value, and the FSM goes to DONE.
  - `rnd` decrements each cycle.
- **DONE**
  - `out_valid=1`. Stay in DONE until `out_ready`, then go to IDLE.
  - `plain` holds its value after the handshake until the next result is written.
- Inputs are sampled only on the accepting edge. Changes to `key`/`cipher` during EXPAND, ROUND or DONE are ignored.
- `in_ready` and `out_valid` are never high in the same cycle. No combinational path exists from `in_valid` or `out_ready` to any output.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - FSM to IDLE
  - `in_ready=1`, `out_valid=0`, `busy=0`
  - `plain`, `state`, all `rk`, `kcache`, `rnd` to 0
  - `key_loaded=0`
- Reset asserted mid-EXPAND or mid-ROUND aborts the operation with no output. The next block always runs a full EXPAND.
- Latency is measured from the accepting edge (edge 0) to the edge that raises `out_valid`:
  - 20 cycles on a cache miss (10 EXPAND + 10 ROUND).
  - 10 cycles on a cache hit.
- Throughput:
  - Cache hit: one block per 12 cycles (IDLE + 10 ROUND + DONE) when `out_ready` is held high.
  - Cache miss: one block per 22 cycles.
- `out_valid` stays high and `plain` stays stable while `out_ready=0`, for any number of cycles.
- A key equal to the cached key but presented after a reset is a miss, because `key_loaded=0`.
- All-zero key with `key_loaded=0` is a miss (no false hit from reset values).

## Test plan
- **FIPS-197 C.1 (cache miss).** Key `000102030405060708090a0b0c0d0e0f`, cipher `69c4e0d86a7b0430d8cdb78070b4c55a` → `plain=00112233445566778899aabbccddeeff`. `out_valid` rises exactly 20 cycles after acceptance.
- **Same key again (cache hit).** Cipher `encrypt_func(key, ffeeddccbbaa99887766554433221100)` → `plain=ffeeddccbbaa99887766554433221100` after exactly 10 cycles.
- **Key change.** Appendix B key `2b7e151628aed2a6abf7158809cf4f3c`, cipher `3925841d02dc09fbdc118597196a0b32` → `plain=3243f6a8885a308d313198a2e0370734`. Latency is 20 cycles.
- **Back-pressure.** Hold `out_ready=0` for 7 cycles in DONE → `out_valid` and `plain` stay constant and `in_ready=0` throughout. Raising `out_ready` gives one handshake, then `in_ready=1` on the next cycle.
- **Mid-operation reset.** Pulse `rst_n` low at ROUND `rnd=5` → all outputs return to reset values immediately, no `out_valid` occurs, and the next block with the same key takes 20 cycles.
- **Random round-trip.** 200 random key/plaintext pairs, with 50% key repeats, encrypted via `encrypt_func` and fed in with random `in_valid`/`out_ready` gaps → every `plain` matches its plaintext, and each latency is 10 or 20 cycles according to cache state.
